// File: rtl/regfile_2w2r_if.sv
// rtl/regfile_2w2r_if.sv - bus interface for the two-write, two-read register file
//
// Purpose: bundles the read ports, both write ports and the flush handshake.
// Ports (signals):
//   raddr1/raddr2, rdata1/rdata2      : read addresses and combinational read data
//   we_x/waddr_x/wdata_x/wbe_x (x=a,b) : write enable, address, data, byte enables
//   flush, busy                        : flush request and flush-in-progress flag
// Modports: master (datapath side), slave (register file side).
interface regfile_2w2r_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0]     raddr1;
  logic [ADDR_W-1:0]     raddr2;
  logic [DATA_W-1:0]     rdata1;
  logic [DATA_W-1:0]     rdata2;
  logic                  we_a;
  logic [ADDR_W-1:0]     waddr_a;
  logic [DATA_W-1:0]     wdata_a;
  logic [DATA_W/8-1:0]   wbe_a;
  logic                  we_b;
  logic [ADDR_W-1:0]     waddr_b;
  logic [DATA_W-1:0]     wdata_b;
  logic [DATA_W/8-1:0]   wbe_b;
  logic                  flush;
  logic                  busy;

  modport master (
    output raddr1, raddr2, we_a, waddr_a, wdata_a, wbe_a,
           we_b, waddr_b, wdata_b, wbe_b, flush,
    input  rdata1, rdata2, busy
  );

  modport slave (
    input  raddr1, raddr2, we_a, waddr_a, wdata_a, wbe_a,
           we_b, waddr_b, wdata_b, wbe_b, flush,
    output rdata1, rdata2, busy
  );
endinterface

// File: rtl/regfile_2w2r.sv
// rtl/regfile_2w2r.sv - parametrised 2-write / 2-read register file with flush engine
//
// Purpose: DEPTH x DATA_W register array with two byte-enabled write ports
// (port B wins per byte on an address collision), two combinational read
// ports with optional write bypass and optional hardwired-zero entry 0, and
// a flush sequencer that zeroes one entry per cycle.
// Ports:
//   clk : clock, all state updates on the rising edge
//   clr : asynchronous active-high reset
//   rf  : regfile_2w2r_if.slave (read ports, write ports, flush/busy)
module regfile_2w2r #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             clr,
  regfile_2w2r_if.slave    rf
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t            state;
  logic [ADDR_W:0]   cnt;
  logic              busy_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              wr_a;
  logic              wr_b;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  // Writes are dropped in the cycle a flush is accepted as well as while busy.
  assign accept = (state == IDLE) && rf.flush;
  assign wr_a   = rf.we_a && !busy_q && !accept &&
                  !((ZERO_REG != 0) && (rf.waddr_a == '0));
  assign wr_b   = rf.we_b && !busy_q && !accept &&
                  !((ZERO_REG != 0) && (rf.waddr_b == '0));

  // Value an entry holds after the edge: B bytes beat A bytes, unenabled bytes keep cur.
  function automatic logic [DATA_W-1:0] merge(
    input logic [DATA_W-1:0] cur,
    input logic              hit_a,
    input logic              hit_b,
    input logic [DATA_W-1:0] da,
    input logic [DATA_W-1:0] db,
    input logic [NB-1:0]     ba,
    input logic [NB-1:0]     bb
  );
    logic [DATA_W-1:0] r;
    r = cur;
    for (int k = 0; k < NB; k++) begin
      if (hit_b && bb[k])      r[8*k +: 8] = db[8*k +: 8];
      else if (hit_a && ba[k]) r[8*k +: 8] = da[8*k +: 8];
    end
    return r;
  endfunction

  always_comb begin
    rd1 = mem[rf.raddr1];
    if (BYPASS != 0)
      rd1 = merge(mem[rf.raddr1], wr_a && (rf.waddr_a == rf.raddr1),
                  wr_b && (rf.waddr_b == rf.raddr1),
                  rf.wdata_a, rf.wdata_b, rf.wbe_a, rf.wbe_b);
    if ((ZERO_REG != 0) && (rf.raddr1 == '0))
      rd1 = '0;
  end

  always_comb begin
    rd2 = mem[rf.raddr2];
    if (BYPASS != 0)
      rd2 = merge(mem[rf.raddr2], wr_a && (rf.waddr_a == rf.raddr2),
                  wr_b && (rf.waddr_b == rf.raddr2),
                  rf.wdata_a, rf.wdata_b, rf.wbe_a, rf.wbe_b);
    if ((ZERO_REG != 0) && (rf.raddr2 == '0))
      rd2 = '0;
  end

  assign rf.rdata1 = rd1;
  assign rf.rdata2 = rd2;
  assign rf.busy   = busy_q;

  // Flush sequencer: the counter carries one spare bit but terminates at DEPTH-1.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rf.flush) begin
            state  <= FLUSH;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        FLUSH: begin
          if (cnt == LAST) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (state == FLUSH) begin
          if (cnt[ADDR_W-1:0] == ADDR_W'(i)) mem[i] <= '0;
        end else begin
          mem[i] <= merge(mem[i], wr_a && (rf.waddr_a == ADDR_W'(i)),
                          wr_b && (rf.waddr_b == ADDR_W'(i)),
                          rf.wdata_a, rf.wdata_b, rf.wbe_a, rf.wbe_b);
        end
      end
    end
  end
endmodule

// File: tb/tb_regfile_2w2r.sv
// tb/tb_regfile_2w2r.sv - self-checking bench for regfile_2w2r (bypass/zero and plain variants)
module tb_regfile_2w2r;
  logic        clk;
  logic        clr;
  logic [4:0]  raddr1, raddr2;
  logic        we_a, we_b, flush;
  logic [4:0]  waddr_a, waddr_b;
  logic [31:0] wdata_a, wdata_b;
  logic [3:0]  wbe_a, wbe_b;

  int total = 0;
  int passed = 0;

  // ifz: ZERO_REG=1, BYPASS=1 ; ifn: ZERO_REG=0, BYPASS=0
  regfile_2w2r_if #(.DATA_W(32), .ADDR_W(5)) ifz ();
  regfile_2w2r_if #(.DATA_W(32), .ADDR_W(5)) ifn ();

  assign ifz.raddr1 = raddr1;   assign ifn.raddr1 = raddr1;
  assign ifz.raddr2 = raddr2;   assign ifn.raddr2 = raddr2;
  assign ifz.we_a = we_a;       assign ifn.we_a = we_a;
  assign ifz.waddr_a = waddr_a; assign ifn.waddr_a = waddr_a;
  assign ifz.wdata_a = wdata_a; assign ifn.wdata_a = wdata_a;
  assign ifz.wbe_a = wbe_a;     assign ifn.wbe_a = wbe_a;
  assign ifz.we_b = we_b;       assign ifn.we_b = we_b;
  assign ifz.waddr_b = waddr_b; assign ifn.waddr_b = waddr_b;
  assign ifz.wdata_b = wdata_b; assign ifn.wdata_b = wdata_b;
  assign ifz.wbe_b = wbe_b;     assign ifn.wbe_b = wbe_b;
  assign ifz.flush = flush;     assign ifn.flush = flush;

  regfile_2w2r #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_z (
    .clk(clk), .clr(clr), .rf(ifz.slave));
  regfile_2w2r #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut_n (
    .clk(clk), .clr(clr), .rf(ifn.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Reference model: plain arrays plus a remaining-flush position.
  logic [31:0] mz [32];
  logic [31:0] mn [32];
  bit          flushing;
  int          fpos;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin mz[i] = 0; mn[i] = 0; end
    flushing = 0;
    fpos = 0;
  endtask

  function automatic logic [31:0] after_write(logic [31:0] cur, int a);
    logic [31:0] r = cur;
    for (int k = 0; k < 4; k++) begin
      if (we_b && waddr_b == 5'(a) && wbe_b[k])      r[8*k +: 8] = wdata_b[8*k +: 8];
      else if (we_a && waddr_a == 5'(a) && wbe_a[k]) r[8*k +: 8] = wdata_a[8*k +: 8];
    end
    return r;
  endfunction

  function automatic bit writes_live();
    return !flushing && !flush;
  endfunction

  function automatic logic [31:0] exp_z(logic [4:0] a);
    if (a == 0) return 32'h0;
    if (writes_live()) return after_write(mz[a], int'(a));
    return mz[a];
  endfunction

  task automatic model_edge();
    if (flushing) begin
      mz[fpos] = 0;
      mn[fpos] = 0;
      fpos++;
      if (fpos == 32) begin flushing = 0; fpos = 0; end
    end else if (flush) begin
      flushing = 1;
      fpos = 0;
    end else begin
      for (int a = 1; a < 32; a++) mz[a] = after_write(mz[a], a);
      for (int a = 0; a < 32; a++) mn[a] = after_write(mn[a], a);
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic check_all();
    check("z_rdata1", ifz.rdata1, exp_z(raddr1));
    check("z_rdata2", ifz.rdata2, exp_z(raddr2));
    check("n_rdata1", ifn.rdata1, mn[raddr1]);
    check("n_rdata2", ifn.rdata2, mn[raddr2]);
    check("z_busy", {31'b0, ifz.busy}, {31'b0, flushing});
    check("n_busy", {31'b0, ifn.busy}, {31'b0, flushing});
  endtask

  task automatic finish_cycle();
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run_cycle();
    #3;
    finish_cycle();
  endtask

  task automatic idle_inputs();
    we_a = 0; waddr_a = 0; wdata_a = 0; wbe_a = 0;
    we_b = 0; waddr_b = 0; wdata_b = 0; wbe_b = 0;
    flush = 0;
  endtask

  typedef struct {
    logic        we_a;
    logic [4:0]  wa_a;
    logic [31:0] wd_a;
    logic [3:0]  be_a;
    logic        we_b;
    logic [4:0]  wa_b;
    logic [31:0] wd_b;
    logic [3:0]  be_b;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] ez1;
    logic [31:0] ez2;
    logic [31:0] en1;
  } vec_t;

  vec_t vt [8];
  int   busy_cycles;

  initial begin
    vt[0] = '{1, 5, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0,        4'h0, 5, 6, 32'hDEADBEEF, 32'h0,        32'h0};
    vt[1] = '{1, 9, 32'h11223344, 4'hF, 0, 0, 32'h0,        4'h0, 5, 9, 32'hDEADBEEF, 32'h11223344, 32'hDEADBEEF};
    vt[2] = '{1, 9, 32'hAAAAAAAA, 4'h3, 1, 9, 32'hBBBBBBBB, 4'h6, 9, 5, 32'h11BBBBAA, 32'hDEADBEEF, 32'h11223344};
    vt[3] = '{0, 0, 32'h0,        4'h0, 0, 0, 32'h0,        4'h0, 9, 9, 32'h11BBBBAA, 32'h11BBBBAA, 32'h11BBBBAA};
    vt[4] = '{1, 0, 32'hFFFFFFFF, 4'hF, 0, 0, 32'h0,        4'h0, 0, 9, 32'h0,        32'h11BBBBAA, 32'h0};
    vt[5] = '{0, 0, 32'h0,        4'h0, 0, 0, 32'h0,        4'h0, 0, 0, 32'h0,        32'h0,        32'hFFFFFFFF};
    vt[6] = '{1, 7, 32'h12345678, 4'h0, 1, 7, 32'h87654321, 4'h0, 7, 7, 32'h0,        32'h0,        32'h0};
    vt[7] = '{1, 7, 32'h11111111, 4'h9, 1, 7, 32'hCAFEF00D, 4'h8, 7, 5, 32'hCA000011, 32'hDEADBEEF, 32'h0};

    idle_inputs();
    raddr1 = 5; raddr2 = 6;
    clr = 0;
    model_reset();
    #2 clr = 1;
    #2;
    check("reset_z_rdata1", ifz.rdata1, 32'h0);
    check("reset_n_rdata2", ifn.rdata2, 32'h0);
    check("reset_busy", {31'b0, ifz.busy}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 clr = 0;

    // Directed vectors: basic write, byte merge/conflict, bypass, zero register, no-op.
    for (int i = 0; i < 8; i++) begin
      we_a = vt[i].we_a; waddr_a = vt[i].wa_a; wdata_a = vt[i].wd_a; wbe_a = vt[i].be_a;
      we_b = vt[i].we_b; waddr_b = vt[i].wa_b; wdata_b = vt[i].wd_b; wbe_b = vt[i].be_b;
      raddr1 = vt[i].r1; raddr2 = vt[i].r2;
      #3;
      check($sformatf("vec%0d_z_rdata1", i), ifz.rdata1, vt[i].ez1);
      check($sformatf("vec%0d_z_rdata2", i), ifz.rdata2, vt[i].ez2);
      check($sformatf("vec%0d_n_rdata1", i), ifn.rdata1, vt[i].en1);
      finish_cycle();
    end
    idle_inputs();

    // Flush: fill, pulse flush (with a write that must be dropped), write and re-flush while busy.
    for (int i = 0; i < 32; i++) begin
      we_a = 1; waddr_a = 5'(i); wdata_a = 32'h100 + i; wbe_a = 4'hF;
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      run_cycle();
    end
    idle_inputs();
    flush = 1; we_b = 1; waddr_b = 3; wdata_b = 32'hFFFF0000; wbe_b = 4'hF;
    run_cycle();
    idle_inputs();
    busy_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      idle_inputs();
      raddr1 = 20; raddr2 = 3;
      if (k == 3) begin
        flush = 1; we_a = 1; waddr_a = 20; wdata_a = 32'hBAD0BAD0; wbe_a = 4'hF;
      end
      if (k == 10) begin raddr1 = 9; raddr2 = 10; end
      #3;
      if (!ifz.busy) break;
      busy_cycles++;
      if (k == 0) check("flush_entry3_kept", ifn.rdata2, 32'h103);
      if (k == 10) begin
        check("flush10_entry9", ifn.rdata1, 32'h0);
        check("flush10_entry10", ifn.rdata2, 32'h10A);
      end
      finish_cycle();
    end
    check("busy_cycles", 32'(busy_cycles), 32'd32);
    idle_inputs();
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      #3;
      check($sformatf("postflush_n_entry%0d", i), ifn.rdata1, 32'h0);
      finish_cycle();
    end

    // Abort a flush with an asynchronous clr between edges.
    we_a = 1; waddr_a = 10; wdata_a = 32'hAB; wbe_a = 4'hF;
    we_b = 1; waddr_b = 20; wdata_b = 32'hCD; wbe_b = 4'hF;
    run_cycle();
    idle_inputs();
    flush = 1;
    run_cycle();
    idle_inputs();
    raddr1 = 10; raddr2 = 20;
    for (int k = 0; k < 7; k++) run_cycle();
    #3;
    check("abort_busy_before", {31'b0, ifz.busy}, 32'h1);
    check("abort_entry20_before", ifn.rdata2, 32'hCD);
    clr = 1;
    model_reset();
    #1;
    check("abort_busy_z", {31'b0, ifz.busy}, 32'h0);
    check("abort_busy_n", {31'b0, ifn.busy}, 32'h0);
    check("abort_entry10", ifn.rdata1, 32'h0);
    check("abort_entry20", ifn.rdata2, 32'h0);
    @(posedge clk);
    #1 clr = 0;
    we_a = 1; waddr_a = 3; wdata_a = 32'h55; wbe_a = 4'hF;
    raddr1 = 3; raddr2 = 10;
    run_cycle();
    idle_inputs();
    #3;
    check("abort_write3", ifn.rdata1, 32'h55);
    finish_cycle();

    // Randomized traffic on a narrow address range to provoke collisions and bypass hits.
    for (int c = 0; c < 400; c++) begin
      we_a = 1'($urandom_range(0, 1)); waddr_a = 5'($urandom_range(0, 7));
      wdata_a = $urandom; wbe_a = 4'($urandom);
      we_b = 1'($urandom_range(0, 1)); waddr_b = 5'($urandom_range(0, 7));
      wdata_b = $urandom; wbe_b = 4'($urandom);
      flush = ($urandom_range(0, 59) == 0);
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr_a : 5'($urandom_range(0, 7));
      raddr2 = ($urandom_range(0, 3) == 0) ? waddr_b : 5'($urandom_range(0, 31));
      run_cycle();
    end
    idle_inputs();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/regfile_2w2r.md
Name: regfile_2w2r

Overview:
Parametrised multi-port register file, successor to the single-write 32x32 register file.
- Two write ports with per-byte enables and a defined same-address priority rule.
- Two combinational read ports with optional write-to-read bypass and optional hardwired-zero entry 0.
- A sequenced flush engine that zeroes the array one entry per cycle without asserting reset.
- Sits between the decode stage (reads) and the writeback/load stages (writes) of the datapath.

Parameters:
DATA_W    32  data width in bits; must be a multiple of 8
ADDR_W    5   address width; DEPTH = 2**ADDR_W entries
ZERO_REG  1   1: entry 0 reads as 0 and ignores writes
BYPASS    1   1: reads return same-cycle write data on address match

Ports:
clk      in   1         clock; all state updates on rising edge
clr      in   1         asynchronous active-high reset
raddr1   in   ADDR_W    read port 1 address
raddr2   in   ADDR_W    read port 2 address
rdata1   out  DATA_W    read port 1 data (combinational)
rdata2   out  DATA_W    read port 2 data (combinational)
we_a     in   1         write enable, port A
waddr_a  in   ADDR_W    write address, port A
wdata_a  in   DATA_W    write data, port A
wbe_a    in   DATA_W/8  byte enables, port A (bit i -> byte i)
we_b     in   1         write enable, port B
waddr_b  in   ADDR_W    write address, port B
wdata_b  in   DATA_W    write data, port B
wbe_b    in   DATA_W/8  byte enables, port B
flush    in   1         request to zero the whole array
busy     out  1         flush in progress; writes ignored

Behaviour:
- Reset: clr=1 immediately, independent of clk:
  - all entries = 0
  - FSM = IDLE, flush counter = 0, busy = 0
  - rdata1/rdata2 therefore read 0
- Writes take effect at the rising edge; they are visible on rdata in the following cycle, or in the same cycle when BYPASS=1.
- A port writes only when all of the following hold:
  - its we = 1
  - busy = 0
  - no flush is being accepted this cycle
  - its waddr is not 0 while ZERO_REG=1
- Byte merge: only bytes with wbe=1 are updated; other bytes keep their stored value. we=1 with wbe=0 is a no-op.
- Same address on both ports, both enabled:
  - a byte enabled on B takes B's byte;
  - a byte enabled only on A takes A's byte.
- Reads: rdataN = entry[raddrN].
  - BYPASS=1 and raddrN matches an active write: rdataN = the value the entry will hold after the edge, with the same byte merge and B-over-A priority.
  - ZERO_REG=1 and raddrN=0: rdataN = 0, overriding everything.
  - Both read ports may use the same address.
- Flush FSM, states IDLE and FLUSH:
  - IDLE: flush=1 -> FLUSH at the next edge, counter=0, busy=1. Writes in the accepting cycle are dropped.
  - FLUSH: each edge writes 0 to entry[counter] and increments counter.
  - After the edge that zeroes entry DEPTH-1 -> IDLE, busy=0, counter=0.
  - busy is high for exactly DEPTH cycles.
  - flush while busy=1 is ignored; there is no queuing.
- During FLUSH, reads return stored contents: entries below counter read 0, the rest keep old data. No write bypass, because writes are blocked.
- clr asserted mid-flush aborts the flush. State is as after reset, and busy drops asynchronously.
- Writes with busy=1 are silently discarded. Upstream must hold writes off when busy=1.
- Address wrap: the counter is ADDR_W+1 bits; the terminal compare is against DEPTH-1, with no overflow into entry 0.

Test Plan:
1. Reset/basic: clr=1 for 2 cycles, release; write A addr 5 = 0xDEADBEEF, wbe=4'hF; next cycle raddr1=5 -> rdata1=0xDEADBEEF; raddr2=6 -> 0.
2. Byte merge and conflict:
   - entry 9 = 0x11223344;
   - same cycle: A writes 9 = 0xAAAAAAAA, wbe=4'b0011; B writes 9 = 0xBBBBBBBB, wbe=4'b0110;
   - result 0x11BBBBAA.
3. Bypass: BYPASS=1; with the entry 9 writes of scenario 2 active, raddr1=9 in the same cycle -> rdata1=0x11BBBBAA before the edge. With BYPASS=0 it shows 0x11223344.
4. Zero register: ZERO_REG=1; A writes 0 = 0xFFFFFFFF -> raddr1=0 reads 0. ZERO_REG=0 -> reads 0xFFFFFFFF.
5. Flush:
   - fill all 32 entries with 0x100+i; pulse flush for 1 cycle;
   - busy high exactly 32 cycles; after 10 busy cycles, entry 9 = 0 and entry 10 = 0x10A;
   - a write to 20 during busy is dropped; after busy falls, all entries read 0;
   - a second flush during busy does not extend it.
6. Abort: start a flush, assert clr asynchronously (between edges) after 7 cycles -> busy falls immediately, all entries 0; a write to 3 = 0x55 after release lands normally.
